// File: rtl/crossbar_rr_scheduler.sv
// rtl/crossbar_rr_scheduler.sv - round-robin scheduler for the 4x4 crossbar
// Per-output arbiters feed registered holding stages; reports winner source and contention.
module crossbar_rr_scheduler #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    input  logic [7:0]       in_dest,
    input  logic [15:0]      in_data,
    output logic [3:0]       in_ready,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [15:0]      out_data,
    output logic [7:0]       out_src,
    output logic [CNT_W-1:0] contention_cnt
);

    logic [1:0] ptr [4];
    logic [3:0] free;
    logic [3:0] win_vld;
    logic [1:0] win_idx [4];

    always_comb begin
        logic [1:0] idx;
        idx = 2'd0;
        for (int o = 0; o < 4; o++) begin
            free[o]    = !out_valid[o] || out_ready[o];
            win_vld[o] = 1'b0;
            win_idx[o] = 2'd0;
            // Scan farthest-first so the candidate nearest ptr overwrites the rest.
            for (int k = 3; k >= 0; k--) begin
                idx = ptr[o] + 2'(k);
                if (in_valid[idx] && (in_dest[2*idx +: 2] == 2'(o))) begin
                    win_vld[o] = 1'b1;
                    win_idx[o] = idx;
                end
            end
            if (!free[o]) begin
                win_vld[o] = 1'b0;
            end
        end
    end

    always_comb begin
        logic [1:0] d;
        d = 2'd0;
        for (int i = 0; i < 4; i++) begin
            d           = in_dest[2*i +: 2];
            in_ready[i] = !rst && win_vld[d] && (win_idx[d] == 2'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= '0;
            out_data       <= '0;
            out_src        <= '0;
            contention_cnt <= '0;
            for (int o = 0; o < 4; o++) begin
                ptr[o] <= 2'd0;
            end
        end else begin
            for (int o = 0; o < 4; o++) begin
                if (win_vld[o]) begin
                    out_valid[o]       <= 1'b1;
                    out_data[4*o +: 4] <= in_data[4*win_idx[o] +: 4];
                    out_src[2*o +: 2]  <= win_idx[o];
                    ptr[o]             <= win_idx[o] + 2'd1;
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
            if ((|(in_valid & ~in_ready)) && (contention_cnt != {CNT_W{1'b1}})) begin
                contention_cnt <= contention_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crossbar_rr_scheduler.sv
// tb/tb_crossbar_rr_scheduler.sv - self-checking bench for crossbar_rr_scheduler
// Cycle model compared on every falling edge, plus directed literal expectations.
module tb_crossbar_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [7:0]  in_dest;
    logic [15:0] in_data;
    logic [3:0]  out_ready;
    logic [3:0]  in_ready, out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_src;
    logic [7:0]  cnt;
    logic [3:0]  s_in_ready, s_out_valid;
    logic [15:0] s_out_data;
    logic [7:0]  s_out_src;
    logic [1:0]  s_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    crossbar_rr_scheduler #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_dest(in_dest), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .contention_cnt(cnt)
    );

    crossbar_rr_scheduler #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_dest(in_dest), .in_data(in_data),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_src(s_out_src), .contention_cnt(s_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model state: holding stages, pointers and counters as plain integers.
    int mv [4];
    int md [4];
    int ms [4];
    int mp [4];
    int mcnt  = 0;
    int mcnt2 = 0;

    always @(negedge clk) begin
        int w [4];
        int i;
        logic [3:0]  er, ev;
        logic [15:0] ed;
        logic [7:0]  es;
        er = '0; ev = '0; ed = '0; es = '0;
        for (int o = 0; o < 4; o++) begin
            w[o] = -1;
            if (!rst && (mv[o] == 0 || out_ready[o])) begin
                for (int k = 0; k < 4; k++) begin
                    i = (mp[o] + k) % 4;
                    if (w[o] < 0 && in_valid[i] && in_dest[2*i +: 2] == o) w[o] = i;
                end
            end
            if (w[o] >= 0) er[w[o]] = 1'b1;
            ev[o]        = (mv[o] != 0);
            ed[4*o +: 4] = 4'(md[o]);
            es[2*o +: 2] = 2'(ms[o]);
        end
        chk("model_in_ready", {28'd0, in_ready}, {28'd0, er});
        chk("model_out_valid", {28'd0, out_valid}, {28'd0, ev});
        chk("model_out_data", {16'd0, out_data}, {16'd0, ed});
        chk("model_out_src", {24'd0, out_src}, {24'd0, es});
        chk("model_cnt", {24'd0, cnt}, 32'(mcnt));
        chk("model_cnt_sat", {30'd0, s_cnt}, 32'(mcnt2));
        if (rst) begin
            for (int o = 0; o < 4; o++) begin
                mv[o] = 0; md[o] = 0; ms[o] = 0; mp[o] = 0;
            end
            mcnt = 0; mcnt2 = 0;
        end else begin
            for (int o = 0; o < 4; o++) begin
                if (w[o] >= 0) begin
                    mv[o] = 1; md[o] = in_data[4*w[o] +: 4]; ms[o] = w[o]; mp[o] = (w[o] + 1) % 4;
                end else if (out_ready[o]) begin
                    mv[o] = 0;
                end
            end
            if ((in_valid & ~er) != 4'd0) begin
                mcnt  = (mcnt  < 255) ? mcnt + 1 : 255;
                mcnt2 = (mcnt2 < 3)   ? mcnt2 + 1 : 3;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [7:0] d,
                         input logic [15:0] dat, input logic [3:0] ordy);
        rst = r; in_valid = v; in_dest = d; in_data = dat; out_ready = ordy;
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_dest = '0; in_data = '0; out_ready = '0;
        tick();
        chk("reset_out_valid", {28'd0, out_valid}, 32'h0);
        chk("reset_out_data", {16'd0, out_data}, 32'h0);
        chk("reset_out_src", {24'd0, out_src}, 32'h0);
        chk("reset_cnt", {24'd0, cnt}, 32'h0);

        // Permutation: every requester to a distinct output.
        drive(1'b0, 4'b1111, 8'h1B, 16'h8421, 4'b1111);
        chk("perm_in_ready", {28'd0, in_ready}, 32'hF);
        tick();
        chk("perm_out_valid", {28'd0, out_valid}, 32'hF);
        chk("perm_out_data", {16'd0, out_data}, 32'h1248);
        chk("perm_out_src", {24'd0, out_src}, 32'h1B);

        drive(1'b1, 4'b0000, 8'h00, 16'h0000, 4'b1111);
        tick();

        // All requesters to output 2: rotating grants.
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 4'b1111, 8'hAA, 16'h7654, 4'b1111);
            chk("rr_in_ready", {28'd0, in_ready}, 32'(1 << (k % 4)));
            tick();
            chk("rr_out_src2", {30'd0, out_src[5:4]}, 32'(k % 4));
            chk("rr_cnt", {24'd0, cnt}, 32'(k + 1));
        end

        drive(1'b1, 4'b0000, 8'h00, 16'h0000, 4'b1111);
        tick();

        // Backpressure on output 1.
        drive(1'b0, 4'b0001, 8'h01, 16'h000A, 4'b1111);
        chk("bp_load_ready", {28'd0, in_ready}, 32'h1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'b1000, 8'h40, 16'hB000, 4'b1101);
            chk("bp_in_ready", {28'd0, in_ready}, 32'h0);
            tick();
            chk("bp_hold_data", {28'd0, out_data[7:4]}, 32'hA);
            chk("bp_hold_valid", {31'd0, out_valid[1]}, 32'h1);
        end
        drive(1'b0, 4'b1000, 8'h40, 16'hB000, 4'b1111);
        chk("bp_release_ready", {28'd0, in_ready}, 32'h8);
        tick();
        chk("bp_new_data", {28'd0, out_data[7:4]}, 32'hB);
        chk("bp_new_src", {30'd0, out_src[3:2]}, 32'h3);

        drive(1'b1, 4'b0000, 8'h00, 16'h0000, 4'b1111);
        tick();

        // Drain and refill output 0 in one cycle.
        drive(1'b0, 4'b0001, 8'h00, 16'h0003, 4'b1111);
        tick();
        chk("dr_first_valid", {31'd0, out_valid[0]}, 32'h1);
        drive(1'b0, 4'b0010, 8'h00, 16'h0050, 4'b1111);
        chk("dr_in_ready", {28'd0, in_ready}, 32'h2);
        tick();
        chk("dr_valid", {31'd0, out_valid[0]}, 32'h1);
        chk("dr_data", {28'd0, out_data[3:0]}, 32'h5);

        drive(1'b1, 4'b0000, 8'h00, 16'h0000, 4'b1111);
        tick();

        // Saturating counter with CNT_W=2.
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 4'b0011, 8'h00, 16'h0021, 4'b1111);
            tick();
            chk("sat_cnt", {30'd0, s_cnt}, (k < 3) ? 32'(k + 1) : 32'd3);
        end

        // Reset mid-operation.
        drive(1'b0, 4'b1111, 8'h1B, 16'h8421, 4'b1111);
        tick();
        chk("mid_full", {28'd0, out_valid}, 32'hF);
        drive(1'b1, 4'b1111, 8'h00, 16'h8421, 4'b0000);
        chk("mid_rst_ready", {28'd0, in_ready}, 32'h0);
        tick();
        chk("mid_out_valid", {28'd0, out_valid}, 32'h0);
        chk("mid_cnt", {24'd0, cnt}, 32'h0);
        drive(1'b0, 4'b1100, 8'h00, 16'hED00, 4'b1111);
        chk("post_rst_ready", {28'd0, in_ready}, 32'h4);
        tick();
        chk("post_rst_src", {30'd0, out_src[1:0]}, 32'h2);
        chk("post_rst_data", {28'd0, out_data[3:0]}, 32'hD);

        drive(1'b0, 4'b0000, 8'h00, 16'h0000, 4'b1111);
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crossbar_rr_scheduler.md
Name: crossbar_rr_scheduler

Overview:
- Scheduler and arbiter in front of the 4x4 4-bit crossbar datapath.
- Four input requesters each present one 4-bit word with a 2-bit destination port.
- Per output port, a round-robin arbiter picks one requester per cycle. The block registers the routed word into a per-output holding stage with valid/ready backpressure.
- It also reports the winning source per output and counts contention cycles.

Parameters:
- CNT_W, 8, width of saturating contention counter

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  4  bit i = requester i has a word
- in_dest  input  8  bits [2i+1:2i] = destination output of requester i
- in_data  input  16  bits [4i+3:4i] = word of requester i
- in_ready  output  4  bit i = requester i accepted this cycle (combinational)
- out_valid  output  4  bit o = output stage o holds a word
- out_ready  input  4  bit o = consumer of output o takes word this cycle
- out_data  output  16  bits [4o+3:4o] = held word for output o
- out_src  output  8  bits [2o+1:2o] = requester index that sourced held word
- contention_cnt  output  CNT_W  cycles with at least one valid, un-accepted requester

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, out_data=0, out_src=0, contention_cnt=0.
  - All four round-robin pointers ptr[o]=0.
  - in_ready is 0 while rst=1.
- Slot free: free[o] = !out_valid[o] | out_ready[o]. The stage may drain and refill in the same cycle, giving full throughput of 1 word/cycle/output.
- Arbitration for output o, combinational each cycle:
  - Candidates are requesters i with in_valid[i] and in_dest[i]==o.
  - Search order is ptr[o], ptr[o]+1, ptr[o]+2, ptr[o]+3 (mod 4). The first candidate wins.
  - No winner if there are no candidates or !free[o].
- in_ready[i] = 1 iff requester i wins the arbiter of its destination. Each requester targets exactly one output, so it receives at most one grant. in_ready never asserts without in_valid.
- On a clock edge with a winner w for output o:
  - out_data[o] <= in_data[w], out_src[o] <= w, out_valid[o] <= 1.
  - ptr[o] <= w+1 mod 4 (wrap 3 -> 0).
- On a clock edge with no winner for o:
  - If out_ready[o], then out_valid[o] <= 0.
  - Otherwise the stage holds data, src and valid unchanged.
  - ptr[o] is unchanged.
- Latency: word accepted in cycle N is visible on out_data/out_valid in cycle N+1.
- Backpressure:
  - While out_valid[o]=1 and out_ready[o]=0, the stage holds stable and no requester is granted output o.
  - The pointer does not move.
- Independent outputs: up to 4 grants per cycle when destinations are distinct. Arbiters share no state.
- contention_cnt:
  - Increments by 1 on each edge where (in_valid & ~in_ready) != 0.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Requester side: a requester not granted may change or withdraw its request. The block keeps no memory of un-granted requests.
- Reset mid-operation: all held words are discarded, valids clear next edge, pointers return to 0. This overrides any simultaneous grant or drain.
- out_ready while out_valid=0 has no effect.
- Unknown or X inputs are not handled; the bench drives all inputs from reset.

Test Plan:
1. Reset, then a permutation: in_valid=4'b1111, in_dest={0,1,2,3} for i=3..0, in_data={8,4,2,1}, out_ready=4'b1111.
   - in_ready=4'b1111 in the same cycle.
   - Next cycle out_valid=4'b1111 and out_data=16'h1248 (out0=8, out1=4, out2=2, out3=1), out_src={0,1,2,3}.
2. All four requesters target output 2 continuously, out_ready=1.
   - Grants follow 0,1,2,3,0 on consecutive cycles, one per cycle.
   - out_src[5:4] follows the same sequence one cycle later.
   - contention_cnt rises by 1 per cycle.
3. Backpressure: output 1 holds word 4'hA, out_ready[1]=0 for 3 cycles while requester 3 targets output 1.
   - in_ready[3]=0 throughout, out_data[7:4]=A stable.
   - When out_ready[1]=1, grant occurs in that cycle and the new word appears next cycle.
4. Drain and refill in the same cycle: out_valid[0]=1, out_ready[0]=1, requester 1 targets output 0 with 4'h5.
   - in_ready[1]=1.
   - Next cycle out_valid[0]=1, out_data[3:0]=5, with no bubble.
5. contention_cnt saturation with CNT_W=2: hold 2 requesters on the same output for 5 cycles.
   - Count sequence is 1,2,3,3,3.
6. Assert rst for one cycle while out_valid=4'b1111 and requests are pending.
   - Next cycle out_valid=0, contention_cnt=0.
   - The first post-reset contention on output 0 between requesters 2 and 3 grants requester 2, since ptr resets to 0.
